// File: rtl/instrs_buff_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction buffer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package instrs_buff_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int PERF_W = 8;

  // One buffered fetch result, instruction word in the upper bits.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } instrs_buff_entry_t;

  // Pointer width for a given depth: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/instrs_buff_mem.sv
// Entry storage: DEPTH flops, one synchronous write port, one async read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module instrs_buff_mem
  import instrs_buff_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  parameter int AW    = ptr_width(DEPTH) - 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Data storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instrs_buff.sv
// Circular fetch-to-decode instruction buffer with flush and perf export (INSTRS_BUFF_PERF_EN).
// Latency: entry pushed at edge N is presented on out_* after edge N; no bypass when empty.
// Backpressure: in_ready drops when full or reloading; out_valid drops when empty or reloading.
module instrs_buff
  import instrs_buff_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 8,
  parameter int ID         = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [PC_WIDTH-1:0]           in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [PC_WIDTH-1:0]           out_pc,
  input  logic                          reload,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic [PERF_W-1:0]             perf_id,
  output logic [PERF_W-1:0]             perf_head,
  output logic [PERF_W-1:0]             perf_tail,
  output logic [PERF_W-1:0]             perf_full,
  output logic [PERF_W-1:0]             perf_reload
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = DATA_WIDTH + PC_WIDTH;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] rd_entry;

  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  // A flush blocks both handshakes in the cycle it is asserted.
  assign in_ready  = !full && !reload;
  assign out_valid = !empty && !reload;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = tail - head;

  // Pointer update: reset and flush both return to zero, flush wins over handshakes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (reload) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  instrs_buff_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (tail[AW-1:0]),
    .wdata ({in_data, in_pc}),
    .raddr (head[AW-1:0]),
    .rdata (rd_entry)
  );

  assign {out_data, out_pc} = rd_entry;

`ifdef INSTRS_BUFF_PERF_EN
  localparam int PAD = PERF_W - AW;

  logic reload_q;

  // Registered flush flag so the perf monitor sees no combinational input path.
  always_ff @(posedge clk) begin
    if (!rst) reload_q <= 1'b0;
    else      reload_q <= reload;
  end

  assign perf_id     = PERF_W'(ID);
  assign perf_head   = {{PAD{1'b0}}, head[AW-1:0]};
  assign perf_tail   = {{PAD{1'b0}}, tail[AW-1:0]};
  assign perf_full   = {{(PERF_W-1){1'b0}}, full};
  assign perf_reload = {{(PERF_W-1){1'b0}}, reload_q};
`else
  // Perf export disabled: every perf output is held low; ID is masked off.
  assign perf_id     = PERF_W'(ID) & {PERF_W{1'b0}};
  assign perf_head   = '0;
  assign perf_tail   = '0;
  assign perf_full   = '0;
  assign perf_reload = '0;
`endif

endmodule

// File: tb/tb_instrs_buff.sv
// Scoreboard bench for instrs_buff: directed fill/drain/wrap/flush/reset sequences.
// Expected entries are queued on accept and checked by an independent output monitor.
module tb_instrs_buff;
  import instrs_buff_pkg::*;

`ifdef INSTRS_BUFF_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int TB_ID = 5;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic        reload;
  logic [3:0]  count;
  logic [7:0]  perf_id;
  logic [7:0]  perf_head;
  logic [7:0]  perf_tail;
  logic [7:0]  perf_full;
  logic [7:0]  perf_reload;

  instrs_buff #(
    .DATA_WIDTH (32),
    .PC_WIDTH   (32),
    .DEPTH      (8),
    .ID         (TB_ID)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_pc      (out_pc),
    .reload      (reload),
    .count       (count),
    .perf_id     (perf_id),
    .perf_head   (perf_head),
    .perf_tail   (perf_tail),
    .perf_full   (perf_full),
    .perf_reload (perf_reload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  instrs_buff_entry_t sb[$];

  // Reference state: 4-bit pointers for an 8-deep buffer, plus registered flush flag.
  logic [3:0] m_head;
  logic [3:0] m_tail;
  logic       m_rq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples shortly before each rising edge and checks every dequeue.
  initial begin
    instrs_buff_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_unexpected: got data 0x%0h with no entry expected at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_pc", 64'(out_pc), 64'(e.pc));
        end
      end
    end
  end

  // One clock of stimulus: drive at the falling edge, check before the rising edge, then advance the model.
  task automatic step(input logic rs, input logic iv, input logic ordy, input logic rld,
                      input logic [31:0] d, input logic [31:0] p);
    logic [3:0] cnt;
    logic       acc_in;
    logic       acc_out;
    instrs_buff_entry_t e;
    rst       = rs;
    in_valid  = iv;
    out_ready = ordy;
    reload    = rld;
    in_data   = d;
    in_pc     = p;
    #4;
    cnt     = m_tail - m_head;
    acc_in  = iv && (cnt != 4'd8) && !rld;
    acc_out = ordy && (cnt != 4'd0) && !rld;
    chk("in_ready", 64'(in_ready), 64'((cnt != 4'd8) && !rld));
    chk("out_valid", 64'(out_valid), 64'((cnt != 4'd0) && !rld));
    chk("count", 64'(count), 64'(cnt));
    chk("perf_head", 64'(perf_head), PERF ? 64'(m_head[2:0]) : 64'd0);
    chk("perf_tail", 64'(perf_tail), PERF ? 64'(m_tail[2:0]) : 64'd0);
    chk("perf_full", 64'(perf_full), PERF ? 64'(cnt == 4'd8) : 64'd0);
    chk("perf_reload", 64'(perf_reload), PERF ? 64'(m_rq) : 64'd0);
    chk("perf_id", 64'(perf_id), PERF ? 64'(TB_ID) : 64'd0);
    if (!rs || rld) begin
      sb.delete();
    end else if (acc_in) begin
      e.data = d;
      e.pc   = p;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!rs) begin
      m_head = '0;
      m_tail = '0;
      m_rq   = 1'b0;
    end else if (rld) begin
      m_head = '0;
      m_tail = '0;
      m_rq   = 1'b1;
    end else begin
      if (acc_in)  m_tail = m_tail + 4'd1;
      if (acc_out) m_head = m_head + 4'd1;
      m_rq = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int maxc;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; reload = 1'b0;
    in_data = '0; in_pc = '0;
    m_head = '0; m_tail = '0; m_rq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, held for two checked cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fill with decode stalled.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + i, 32'h8000_0000 + 4 * i);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_perf_full", 64'(perf_full), PERF ? 64'd1 : 64'd0);
    chk("fill_perf_tail", 64'(perf_tail), 64'd0);
    chk("fill_perf_head", 64'(perf_head), 64'd0);
    // A ninth offer must be refused.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1FF, 32'h8000_00FC);

    // Drain in order.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);

    // Streaming across pointer wrap.
    maxc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h200 + i, 32'h8000_1000 + 4 * i);
      if (int'(count) > maxc) maxc = int'(count);
    end
    chk("wrap_max_count", 64'(maxc), 64'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wrap_drained", 64'(count), 64'd0);

    // Full with simultaneous pop: pop only.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300 + i, 32'h8000_2000 + 4 * i);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h3FF, 32'h8000_20FC);
    chk("fullpop_count", 64'(count), 64'd7);
    chk("fullpop_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 7; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Flush at count 5 with both handshakes offered.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h400 + i, 32'h8000_3000 + 4 * i);
    chk("pre_reload_count", 64'(count), 64'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h4FF, 32'h8000_30FC);
    chk("reload_count", 64'(count), 64'd0);
    chk("reload_perf_reload", 64'(perf_reload), PERF ? 64'd1 : 64'd0);
    chk("reload_perf_head", 64'(perf_head), 64'd0);
    chk("reload_perf_tail", 64'(perf_tail), 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("b2b_perf_reload", 64'(perf_reload), PERF ? 64'd1 : 64'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("reload_drop", 64'(perf_reload), 64'd0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h450 + i, 32'h8000_3100 + 4 * i);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    // Reset mid-stream at count 3.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h500 + i, 32'h8000_4000 + 4 * i);
    chk("pre_rst_count", 64'(count), 64'd3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h5FF, 32'h8000_40FC);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_perf_head", 64'(perf_head), 64'd0);
    chk("rst_perf_tail", 64'(perf_tail), 64'd0);
    chk("rst_perf_full", 64'(perf_full), 64'd0);
    chk("rst_perf_reload", 64'(perf_reload), 64'd0);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h600 + i, 32'h8000_5000 + 4 * i);
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
